// File: rtl/bpred_unit.sv
// Direct-mapped BTB branch predictor with saturating direction counters.
// Combinational lookup at fetch, training from resolve, saturating statistics.
module bpred_unit #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_f,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_mispredict,
    input  logic              flush_all,
    output logic [STAT_W-1:0] n_branches,
    output logic [STAT_W-1:0] n_mispred
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

    logic              valid_q  [ENTRIES];
    logic              valid_d  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_d    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [ADDR_W-1:0] target_d [ENTRIES];
    logic [CNT_W-1:0]  cnt_q    [ENTRIES];
    logic [CNT_W-1:0]  cnt_d    [ENTRIES];

    logic [STAT_W-1:0] n_branches_q, n_branches_d;
    logic [STAT_W-1:0] n_mispred_q, n_mispred_d;

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;

    assign lk_idx  = pc_f[IDX_W+1:2];
    assign lk_tag  = pc_f[ADDR_W-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Lookup reads only registered state, so a same-cycle update is not bypassed.
    always_comb begin
        pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = pred_hit && cnt_q[lk_idx][CNT_W-1];
        pred_target = pred_taken ? target_q[lk_idx] : (pc_f + ADDR_W'(4));
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (cnt_q[upd_idx] != CNT_MAX) begin
                        cnt_d[upd_idx] = cnt_q[upd_idx] + CNT_W'(1);
                    end
                    target_d[upd_idx] = upd_target;
                end else if (cnt_q[upd_idx] != '0) begin
                    cnt_d[upd_idx] = cnt_q[upd_idx] - CNT_W'(1);
                end
            end else if (upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                cnt_d[upd_idx]    = CNT_WT;
            end
        end
    end

    // Statistics keep counting through a flush and stick at all-ones.
    always_comb begin
        n_branches_d = n_branches_q;
        n_mispred_d  = n_mispred_q;
        if (upd_valid) begin
            if (n_branches_q != '1) begin
                n_branches_d = n_branches_q + STAT_W'(1);
            end
            if (upd_mispredict && (n_mispred_q != '1)) begin
                n_mispred_d = n_mispred_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WNT;
            end
            n_branches_q <= '0;
            n_mispred_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            target_q     <= target_d;
            cnt_q        <= cnt_d;
            n_branches_q <= n_branches_d;
            n_mispred_q  <= n_mispred_d;
        end
    end

    assign n_branches = n_branches_q;
    assign n_mispred  = n_mispred_q;

endmodule
